// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 round sequencer.
// Loads a byte-serial key/plaintext pair into 128-bit registers, then drives one shared
// round datapath through rounds 0..NUM_ROUNDS. Round 0 is the initial AddRoundKey. Each
// round is issued as a one-cycle command carrying its round constant and final-round flag.
// The final datapath result is streamed out byte-serially, MSB first.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         handshake for one key_byte/state_byte pair
//   key_byte, state_byte      key and plaintext bytes, MSB-first
//   out_valid/out_ready       handshake for out_byte
//   out_byte                  ciphertext byte, MSB-first
//   busy                      block in flight (ROUND/WAIT/UNLOAD)
//   err                       sticky round-timeout flag
//   dp_key, dp_state          assembled key and plaintext for the datapath
//   dp_round_start            one-cycle round command
//   dp_round_num, dp_rcon     round index and key-expansion constant
//   dp_final                  final round (no MixColumns)
//   dp_round_done, dp_result  datapath completion and its state output
module aes_round_sequencer #(
  parameter int unsigned NUM_ROUNDS   = 10,
  parameter int unsigned DONE_TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   key_byte,
  input  logic [7:0]   state_byte,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   out_byte,
  output logic         busy,
  output logic         err,
  output logic [127:0] dp_key,
  output logic [127:0] dp_state,
  output logic         dp_round_start,
  output logic [3:0]   dp_round_num,
  output logic [7:0]   dp_rcon,
  output logic         dp_final,
  input  logic         dp_round_done,
  input  logic [127:0] dp_result
);

  localparam int unsigned TmoW = $clog2(DONE_TIMEOUT + 1);

  typedef enum logic [1:0] {StLoad, StRound, StWait, StUnload} state_e;

  state_e          state_q, state_d;
  logic [3:0]      byte_cnt_q, byte_cnt_d;
  logic [3:0]      round_cnt_q, round_cnt_d;
  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [127:0]    key_q, key_d;
  logic [127:0]    pt_q, pt_d;
  logic [127:0]    shift_q, shift_d;
  logic            err_q, err_d;
  logic [6:0]      lane_lo;
  logic            cmd_active;

  // Round constant: 00 for the initial AddRoundKey, then successive GF(2^8) doublings of 01.
  function automatic logic [7:0] rcon_of(input logic [3:0] rnd);
    logic [7:0] rc;
    rc = 8'h01;
    for (int unsigned i = 2; i < 16; i++) begin
      if (i <= 32'(rnd)) begin
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
    end
    if (rnd == 4'd0) begin
      rc = 8'h00;
    end
    return rc;
  endfunction

  // Byte n lands at bits [127-8n -: 8], i.e. low bit index (15-n)*8.
  assign lane_lo = {~byte_cnt_q, 3'b000};

  always_comb begin
    state_d        = state_q;
    byte_cnt_d     = byte_cnt_q;
    round_cnt_d    = round_cnt_q;
    tmo_cnt_d      = tmo_cnt_q;
    key_d          = key_q;
    pt_d           = pt_q;
    shift_d        = shift_q;
    err_d          = err_q;
    in_ready       = 1'b0;
    out_valid      = 1'b0;
    dp_round_start = 1'b0;

    unique case (state_q)
      StLoad: begin
        in_ready = 1'b1;
        if (in_valid) begin
          key_d[lane_lo +: 8] = key_byte;
          pt_d[lane_lo +: 8]  = state_byte;
          byte_cnt_d          = byte_cnt_q + 4'd1;
          if (byte_cnt_q == 4'd15) begin
            round_cnt_d = 4'd0;
            state_d     = StRound;
          end
        end
      end

      StRound: begin
        dp_round_start = 1'b1;
        tmo_cnt_d      = '0;
        state_d        = StWait;
      end

      StWait: begin
        // Completion takes priority over a timeout expiring in the same cycle.
        if (dp_round_done) begin
          if (round_cnt_q == 4'(NUM_ROUNDS)) begin
            shift_d    = dp_result;
            byte_cnt_d = 4'd0;
            state_d    = StUnload;
          end else begin
            round_cnt_d = round_cnt_q + 4'd1;
            state_d     = StRound;
          end
        end else if (tmo_cnt_q == TmoW'(DONE_TIMEOUT - 1)) begin
          // Abort the block; the partial result is discarded.
          err_d       = 1'b1;
          tmo_cnt_d   = '0;
          round_cnt_d = 4'd0;
          byte_cnt_d  = 4'd0;
          state_d     = StLoad;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TmoW'(1);
        end
      end

      StUnload: begin
        out_valid = 1'b1;
        if (out_ready) begin
          shift_d    = {shift_q[119:0], 8'h00};
          byte_cnt_d = byte_cnt_q + 4'd1;
          if (byte_cnt_q == 4'd15) begin
            round_cnt_d = 4'd0;
            state_d     = StLoad;
          end
        end
      end

      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StLoad;
      byte_cnt_q  <= 4'd0;
      round_cnt_q <= 4'd0;
      tmo_cnt_q   <= '0;
      key_q       <= '0;
      pt_q        <= '0;
      shift_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      round_cnt_q <= round_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      key_q       <= key_d;
      pt_q        <= pt_d;
      shift_q     <= shift_d;
      err_q       <= err_d;
    end
  end

  // Round command fields are only meaningful (and held) while a round is in flight.
  assign cmd_active   = (state_q == StRound) || (state_q == StWait);
  assign dp_round_num = cmd_active ? round_cnt_q : 4'd0;
  assign dp_rcon      = cmd_active ? rcon_of(round_cnt_q) : 8'h00;
  assign dp_final     = cmd_active && (round_cnt_q == 4'(NUM_ROUNDS));

  assign busy     = (state_q != StLoad);
  assign err      = err_q;
  assign dp_key   = key_q;
  assign dp_state = pt_q;
  // Shift register is zero outside UNLOAD (cleared on reset, drained by a full unload).
  assign out_byte = shift_q[127:120];

endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
- Iterative controller for the AES-128 encryption round datapath. It replaces the unrolled 10-stage enable chain with one shared round unit that is re-used for every round.
- Assembles the byte-serial key and plaintext into 128-bit registers, then issues 11 round commands (initial AddRoundKey, rounds 1..NUM_ROUNDS) with the round constant and final-round flag for each.
- Collects the ciphertext and streams it out byte-serially under valid/ready handshakes.

Parameters:
- NUM_ROUNDS, 10, last round index; this round skips MixColumns.
- DONE_TIMEOUT, 64, maximum WAIT cycles per round before an error abort.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- in_valid  in  1  key_byte/state_byte pair valid
- in_ready  out  1  sequencer accepts an input pair
- key_byte  in  8  key byte, MSB-first
- state_byte  in  8  plaintext byte, MSB-first
- out_valid  out  1  out_byte valid
- out_ready  in  1  sink accepts out_byte
- out_byte  out  8  ciphertext byte, MSB-first
- busy  out  1  high in ROUND/WAIT/UNLOAD
- err  out  1  sticky round-timeout flag
- dp_key  out  128  cipher key to the datapath
- dp_state  out  128  plaintext to the datapath
- dp_round_start  out  1  one-cycle round command
- dp_round_num  out  4  round index, 0..NUM_ROUNDS
- dp_rcon  out  8  round constant for key expansion
- dp_final  out  1  final round (no MixColumns)
- dp_round_done  in  1  datapath round complete
- dp_result  in  128  datapath state after the completed round

Behaviour:
- Reset:
  - state=LOAD; byte/round/timeout counters 0.
  - All outputs 0 except in_ready=1.
  - dp_key, dp_state, err and the output shift register are cleared.
  - Reset wins over every other event, including mid-round and mid-unload.
- FSM states: LOAD, ROUND, WAIT, UNLOAD.
- LOAD:
  - in_ready=1. A transfer occurs when in_valid&&in_ready.
  - Byte n (0..15) is written to dp_key[127-8n -: 8] and dp_state[127-8n -: 8].
  - On the 16th transfer: round_cnt<=0, go to ROUND.
  - dp_key/dp_state are registered and hold from load completion until the next LOAD.
- ROUND (one cycle):
  - dp_round_start=1; dp_round_num=round_cnt; dp_final=(round_cnt==NUM_ROUNDS).
  - dp_rcon=00 for round 0; for rounds 1..10 the sequence is 01,02,04,08,10,20,40,80,1B,36.
  - Timeout counter cleared. Go to WAIT.
  - dp_round_num, dp_rcon and dp_final hold their values through WAIT.
- WAIT:
  - dp_round_done is sampled only here; a pulse outside WAIT is ignored.
  - On done with round_cnt<NUM_ROUNDS: round_cnt++, go to ROUND.
  - On done with round_cnt==NUM_ROUNDS: capture dp_result into the output shift register, go to UNLOAD.
  - Otherwise the timeout counter increments. When it reaches DONE_TIMEOUT: err<=1, counters cleared, go to LOAD (block discarded).
  - done and timeout in the same cycle: done wins.
- Latency:
  - Datapath asserts done L>=1 cycles after dp_round_start, so each round takes L+1 cycles.
  - First out_valid occurs 11*(L+1)+1 cycles after the clock edge accepting the 16th input byte (23 for L=1).
- UNLOAD:
  - out_valid=1, out_byte=shift[127:120].
  - On out_ready: shift left by 8 and increment the byte count.
  - out_byte/out_valid stay stable while out_ready=0.
  - After the 16th accepted byte: out_valid=0, go to LOAD the next cycle. No bubble-free overlap with the next load.
- in_ready=0 outside LOAD; in_valid is ignored while busy.
- err clears only on rst.

Test Plan:
- Load with in_valid gaps, key 000102..0f and plaintext 00112233..ff -> dp_key=000102030405060708090a0b0c0d0e0f, dp_state=00112233445566778899aabbccddeeff; dp_round_start with round_num=0 one cycle after the 16th transfer.
- Datapath stub L=1 -> dp_round_num 0..10 with dp_rcon 00,01,02,04,08,10,20,40,80,1B,36; dp_final=1 only at round 10; out_valid exactly 23 cycles after the last input accept.
- Stub returns dp_result=69c4e0d86a7b0430d8cdb78070b4c55a, out_ready random -> bytes 69,c4,e0,d8,…,c5,5a in order, each held stable under backpressure; returns to LOAD with in_ready=1.
- Withhold dp_round_done in round 3 -> after 64 WAIT cycles err=1, busy=0, in_ready=1; a following full block still completes correctly and err stays 1.
- rst asserted in WAIT of round 5, and separately after 7 bytes unloaded -> next cycle all outputs 0, in_ready=1, err=0; a subsequent block completes normally.
- dp_round_done pulsed during LOAD/UNLOAD, and in_valid held high while busy -> no state change, no extra round command, no input bytes accepted.
